matrix_input_parser: RTL and testbench
======================================

# matrix_input_parser

Receive-side counterpart of the matrix info display. It consumes ASCII bytes from the UART receiver and parses one matrix in the form "rows cols e0 e1 … e(rows·cols−1)" as decimal tokens. It validates the dimensions and element range, then streams the elements into the multi-matrix storage write port. It sits between `uart_rx` and the storage block, armed by the top-level control FSM.

## Interface
Parameters:
- `MAX_SIZE`, default 5: largest legal rows/cols; smallest is 1.
- `DATA_WIDTH`, default 8: element width. Legal element range is 0..2^DATA_WIDTH−1.
- `IDX_WIDTH`, default 5: element index width. Must satisfy 2^IDX_WIDTH ≥ MAX_SIZE².

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `start_req`  in  1  arm pulse; sampled only in IDLE.
- `busy`  out  1  high from arm until DONE or ERROR is exited.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid.
- `rx_data`  in  8  received ASCII byte.
- `wr_start`  out  1  one-cycle pulse: new matrix header; `wr_row`/`wr_col` valid.
- `wr_row`, `wr_col`  out  3 each  parsed dimensions; held until next `wr_start`.
- `wr_en`  out  1  one-cycle element write strobe.
- `wr_idx`  out  IDX_WIDTH  row-major element index, starting at 0.
- `wr_data`  out  DATA_WIDTH  element value.
- `wr_done`  out  1  one-cycle commit pulse; storage makes the matrix visible only on this pulse.
- `done`  out  1  one-cycle success pulse, coincident with `wr_done`.
- `err`  out  1  sticky error flag; cleared on next accepted `start_req`.
- `err_code`  out  2  error cause: 0 none, 1 illegal character, 2 dimension out of range, 3 element overflow.

## Operation
- **States:** IDLE, GET_ROW, GET_COL, GET_ELEM, COMMIT, DRAIN.
- **IDLE:**
  - `start_req` → GET_ROW, `busy`=1, `err`/`err_code` cleared, element counter 0.
  - Any `rx_valid` byte is ignored.
- **Token lexing:** applies only on `rx_valid` cycles.
  - Digit '0'..'9': acc ← acc·10 + d, and `pend`=1.
  - Delimiter (0x20, 0x0D, 0x0A):
    - If `pend`=1, the token completes; acc and `pend` are cleared.
    - If `pend`=0, the delimiter is ignored, so runs of whitespace are legal.
  - Any other byte → error code 1.
- **Accumulator:** width DATA_WIDTH+4. An overflow flag sets once acc exceeds 2^DATA_WIDTH−1; acc then saturates at that value plus 1 and never wraps.
- **GET_ROW token complete:**
  - Value in 1..MAX_SIZE → latch `wr_row`, go to GET_COL.
  - Otherwise → error code 2.
- **GET_COL token complete:**
  - Value in range → latch `wr_col`, pulse `wr_start`, compute total = row·col, go to GET_ELEM.
  - Otherwise → error code 2.
- **GET_ELEM token complete:**
  - Overflow flag set → error code 3.
  - Otherwise pulse `wr_en` with `wr_idx`=count and `wr_data`=acc, then count+1.
  - If count+1 == total → COMMIT.
- **COMMIT:** pulse `wr_done` and `done`, `busy`←0, go to IDLE. Bytes after the final element are ignored, since IDLE ignores them.
- **Error path:** set `err`, latch `err_code`, go to DRAIN.
  - DRAIN discards bytes until LF (0x0A) is received, then goes to IDLE with `busy`←0.
  - If the error byte is itself LF, return to IDLE immediately.
  - No `wr_done` is issued on this path, so the partial matrix is never committed.
- **Concurrent events:**
  - `start_req` outside IDLE is ignored.
  - `start_req` and `rx_valid` in the same IDLE cycle: arm takes effect; the byte is ignored.
- **Reset mid-operation:** return to IDLE, all outputs cleared, no `wr_done`.

## Timing
- **Reset values:**
  - `busy`, `wr_start`, `wr_en`, `wr_done`, `done`, `err` = 0.
  - `err_code`, `wr_row`, `wr_col`, `wr_idx`, `wr_data` = 0.
- **Latency:** the delimiter completing a token is accepted at cycle t.
  - `wr_start` / `wr_en` are high at t+1, for exactly one cycle.
  - For the last element, `wr_done` and `done` are high at t+2.
  - An error is visible on `err` at t+1.
- **Byte rate:** one byte accepted per `rx_valid`, back-to-back strobes on consecutive cycles supported. The block has no backpressure; storage must accept `wr_en` every cycle.
- **Pulse outputs:** all strobes are registered and single-cycle.

## Structure
- **Shared package `matrix_pkg`:**
  - `MAX_SIZE`.
  - ASCII constants: `ASCII_0`, `ASCII_SP`, `ASCII_CR`, `ASCII_LF`.
  - Error-code localparams: `ERR_NONE`, `ERR_CHAR`, `ERR_DIM`, `ERR_OVF`.
  - Parser state enum.
- **Sub-module `ascii_num_accum`:**
  - Inputs: `clk`, `rst_n`, `clr`, `digit_valid`, `digit[3:0]`.
  - Outputs: acc, `pend`, overflow.
  - The parser FSM owns the token completion and validation logic.

## Test plan
- **Nominal 2×3:** arm, send "2 3\n1 2 3\n4 5 6\n" → `wr_start` with row=2, col=3; six `wr_en` with idx 0..5 and data 1..6; one `wr_done`/`done`; `err`=0.
- **Bad dimension:** arm, send "6 2\n9 9\n" → `err`=1, `err_code`=2 one cycle after the space following '6'; no `wr_start`; after the first LF `busy`=0; the following "9 9\n" is ignored.
- **Overflow:** with DATA_WIDTH=8, arm, send "1 1\n256 " → `err_code`=3, no `wr_en`. Sending "255 " instead → `wr_data`=255 then `done`.
- **Whitespace and illegal character:**
  - Arm, send "  1   1\r\n7\r\n" → single `wr_en` with idx 0, data 7, then `done`.
  - Separately, arm and send "1 1\nx\n" → `err_code`=1; IDLE after LF.
- **Reset and re-arm:**
  - Assert `rst_n`=0 after the third element of a 2×2 matrix → all outputs 0, no `wr_done`.
  - Re-arm, send "1 2 3 4\n" → `wr_start` with row=1, col=2; `wr_en` with data 3, 4; `done`.
- **Busy protection:** `start_req` pulsed mid-parse → ignored; `rx_valid` bytes in IDLE → no outputs.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, error codes and parser state type for the matrix
// receive path.
package matrix_pkg;

  localparam int MAX_SIZE = 5;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_DIM  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ROW,
    S_GET_COL,
    S_GET_ELEM,
    S_COMMIT,
    S_DRAIN
  } parse_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    return (b == ASCII_SP) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/ascii_num_accum.sv
// Decimal token accumulator. Builds acc = acc*10 + digit and saturates one
// above the largest legal element value so an oversized token can never
// wrap back into the legal range.
module ascii_num_accum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  output logic [DATA_WIDTH+3:0] acc,
  output logic                  pend,
  output logic                  overflow
);

  localparam int AW = DATA_WIDTH + 4;
  localparam logic [AW:0] LIMIT = {{(AW + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [AW:0] SAT   = LIMIT + (AW + 1)'(1);

  logic [AW-1:0] acc_q, acc_d;
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   prod;

  // Next accumulator value; clear has priority over a new digit.
  always_comb begin
    prod   = ({1'b0, acc_q} * (AW + 1)'(10)) + {{(AW - 3){1'b0}}, digit};
    acc_d  = acc_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clr) begin
      acc_d  = '0;
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (digit_valid) begin
      pend_d = 1'b1;
      if (prod > LIMIT) begin
        ovf_d = 1'b1;
        acc_d = SAT[AW-1:0];
      end else begin
        acc_d = prod[AW-1:0];
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign acc      = acc_q;
  assign pend     = pend_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/matrix_input_parser.sv
// Parses "rows cols e0 e1 ..." from the UART byte stream and streams the
// elements into the matrix storage write port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start_req, received bytes ignored
// S_GET_ROW  | lexing the row-count token
// S_GET_COL  | lexing the column-count token, wr_start on completion
// S_GET_ELEM | lexing elements, one wr_en per completed token
// S_COMMIT   | one cycle: wr_done/done, then back to idle
// S_DRAIN    | after an error, discard bytes until LF
module matrix_input_parser #(
  parameter int MAX_SIZE   = matrix_pkg::MAX_SIZE,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_req,
  output logic                  busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  wr_start,
  output logic [2:0]            wr_row,
  output logic [2:0]            wr_col,
  output logic                  wr_en,
  output logic [IDX_WIDTH-1:0]  wr_idx,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  import matrix_pkg::*;

  localparam int AW = DATA_WIDTH + 4;
  localparam int CW = IDX_WIDTH + 1;
  localparam logic [AW-1:0] DIM_MAX = AW'(MAX_SIZE);
  localparam logic [AW-1:0] DIM_MIN = AW'(1);

  parse_state_e state_q, state_d;

  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  wr_start_q, wr_start_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_done_q, wr_done_d;
  logic                  done_q, done_d;
  logic [2:0]            row_tmp_q, row_tmp_d;
  logic [2:0]            wr_row_q, wr_row_d;
  logic [2:0]            wr_col_q, wr_col_d;
  logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         total_q, total_d;
  logic [CW-1:0]         count_inc;

  logic [AW-1:0] acc;
  logic          pend;
  logic          acc_ovf;

  logic in_tok, byte_digit, byte_delim;
  logic digit_valid, acc_clr, tok_done, bad_char, dim_ok;
  logic raise;
  logic [1:0] raise_code;

  // Byte classification; only token-lexing states feed the accumulator.
  always_comb begin
    in_tok      = (state_q == S_GET_ROW) || (state_q == S_GET_COL) ||
                  (state_q == S_GET_ELEM);
    byte_digit  = is_digit(rx_data);
    byte_delim  = is_delim(rx_data);
    digit_valid = in_tok && rx_valid && byte_digit;
    acc_clr     = !in_tok || (rx_valid && byte_delim);
    tok_done    = in_tok && rx_valid && byte_delim && pend;
    bad_char    = in_tok && rx_valid && !byte_digit && !byte_delim;
    dim_ok      = (acc >= DIM_MIN) && (acc <= DIM_MAX);
    count_inc   = count_q + CW'(1);
  end

  ascii_num_accum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (acc_clr),
    .digit_valid (digit_valid),
    .digit       (rx_data[3:0]),
    .acc         (acc),
    .pend        (pend),
    .overflow    (acc_ovf)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    wr_start_d = 1'b0;
    wr_en_d    = 1'b0;
    wr_done_d  = 1'b0;
    done_d     = 1'b0;
    row_tmp_d  = row_tmp_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    total_d    = total_q;
    raise      = 1'b0;
    raise_code = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d    = S_GET_ROW;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          count_d    = '0;
        end
      end
      S_GET_ROW: begin
        if (bad_char) begin
          raise      = 1'b1;
          raise_code = ERR_CHAR;
        end else if (tok_done) begin
          if (dim_ok) begin
            row_tmp_d = acc[2:0];
            state_d   = S_GET_COL;
          end else begin
            raise      = 1'b1;
            raise_code = ERR_DIM;
          end
        end
      end
      S_GET_COL: begin
        if (bad_char) begin
          raise      = 1'b1;
          raise_code = ERR_CHAR;
        end else if (tok_done) begin
          if (dim_ok) begin
            // Row is only published together with col so storage sees a
            // consistent header on the wr_start pulse.
            wr_start_d = 1'b1;
            wr_row_d   = row_tmp_q;
            wr_col_d   = acc[2:0];
            total_d    = CW'(row_tmp_q) * CW'(acc[2:0]);
            count_d    = '0;
            state_d    = S_GET_ELEM;
          end else begin
            raise      = 1'b1;
            raise_code = ERR_DIM;
          end
        end
      end
      S_GET_ELEM: begin
        if (bad_char) begin
          raise      = 1'b1;
          raise_code = ERR_CHAR;
        end else if (tok_done) begin
          if (acc_ovf) begin
            raise      = 1'b1;
            raise_code = ERR_OVF;
          end else begin
            wr_en_d   = 1'b1;
            wr_idx_d  = count_q[IDX_WIDTH-1:0];
            wr_data_d = acc[DATA_WIDTH-1:0];
            count_d   = count_inc;
            if (count_inc == total_q) begin
              state_d = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: begin
        wr_done_d = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      S_DRAIN: begin
        if (rx_valid && (rx_data == ASCII_LF)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // An LF that itself triggers the error already ends the line.
    if (raise) begin
      err_d      = 1'b1;
      err_code_d = raise_code;
      if (rx_data == ASCII_LF) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        state_d = S_DRAIN;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_done_q  <= 1'b0;
      done_q     <= 1'b0;
      row_tmp_q  <= '0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wr_start_q <= wr_start_d;
      wr_en_q    <= wr_en_d;
      wr_done_q  <= wr_done_d;
      done_q     <= done_d;
      row_tmp_q  <= row_tmp_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      total_q    <= total_d;
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign wr_start = wr_start_q;
  assign wr_en    = wr_en_q;
  assign wr_done  = wr_done_q;
  assign done     = done_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_idx   = wr_idx_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_matrix_input_parser.sv
// Bench for matrix_input_parser: a token-level reference parser predicts
// each write-port event and the busy/err levels with their cycle stamps.
module tb_matrix_input_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy, wr_start, wr_en, wr_done, done, err;
  logic [2:0] wr_row, wr_col;
  logic [4:0] wr_idx;
  logic [7:0] wr_data;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  matrix_input_parser #(
    .MAX_SIZE   (5),
    .DATA_WIDTH (8),
    .IDX_WIDTH  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (start_req),
    .busy      (busy),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .wr_start  (wr_start),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int stamp;
    int a;
    int b;
  } ev_t;

  ev_t q_start[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  int m_phase;  // 0 idle, 1 row, 2 col, 3 elements, 4 drain
  int m_acc, m_pend, m_row, m_col, m_cnt, m_total;
  int busy_prev, busy_new, busy_stamp;
  int err_prev, err_new, code_prev, code_new, err_stamp;

  function automatic ev_t mk_ev(input int st, input int a, input int b);
    ev_t e;
    e.stamp = st;
    e.a = a;
    e.b = b;
    return e;
  endfunction

  function automatic void sched_busy(input int v, input int st);
    busy_prev = busy_new;
    busy_new = v;
    busy_stamp = st;
  endfunction

  function automatic void sched_err(input int v, input int code, input int st);
    err_prev = err_new;
    code_prev = code_new;
    err_new = v;
    code_new = code;
    err_stamp = st;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_acc = 0; m_pend = 0; m_row = 0; m_col = 0; m_cnt = 0; m_total = 0;
    busy_prev = 0; busy_new = 0; busy_stamp = 0;
    err_prev = 0; err_new = 0; code_prev = 0; code_new = 0; err_stamp = 0;
    q_start.delete(); q_wr.delete(); q_done.delete();
  endfunction

  function automatic void model_arm(input int t1);
    if (m_phase == 0) begin
      m_phase = 1; m_acc = 0; m_pend = 0;
      sched_busy(1, t1);
      sched_err(0, 0, t1);
    end
  endfunction

  function automatic void model_error(input int code, input logic [7:0] b, input int t1);
    sched_err(1, code, t1);
    if (b == 8'h0A) begin
      m_phase = 0;
      sched_busy(0, t1);
    end else begin
      m_phase = 4;
    end
  endfunction

  function automatic void model_token(input int v, input logic [7:0] b, input int t1);
    case (m_phase)
      1: if (v >= 1 && v <= 5) begin m_row = v; m_phase = 2; end
         else model_error(2, b, t1);
      2: if (v >= 1 && v <= 5) begin
           m_col = v;
           q_start.push_back(mk_ev(t1, m_row, m_col));
           m_total = m_row * m_col;
           m_cnt = 0;
           m_phase = 3;
         end else model_error(2, b, t1);
      3: if (v > 255) model_error(3, b, t1);
         else begin
           q_wr.push_back(mk_ev(t1, m_cnt, v));
           m_cnt++;
           if (m_cnt == m_total) begin
             q_done.push_back(mk_ev(t1 + 1, 0, 0));
             sched_busy(0, t1 + 1);
             m_phase = 0;
           end
         end
      default: ;
    endcase
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int t1);
    if (m_phase >= 1 && m_phase <= 3) begin
      if (b >= 8'h30 && b <= 8'h39) begin
        if (m_acc < 100000) m_acc = m_acc * 10 + (int'(b) - 48);
        m_pend = 1;
      end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
        if (m_pend != 0) model_token(m_acc, b, t1);
        m_acc = 0;
        m_pend = 0;
      end else begin
        model_error(1, b, t1);
      end
    end else if (m_phase == 4) begin
      if (b == 8'h0A) begin
        m_phase = 0;
        sched_busy(0, t1);
      end
    end
  endfunction

  // ---------------- observation log ----------------
  int n_start, n_wr, n_done, sum_data, last_data, last_idx, last_row, last_col;

  task automatic clear_obs();
    n_start = 0; n_wr = 0; n_done = 0; sum_data = 0;
    last_data = -1; last_idx = -1; last_row = -1; last_col = -1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin : compare
    ev_t e;
    if (rst_n) begin
      if (wr_start) begin
        n_start++; last_row = wr_row; last_col = wr_col;
        if (q_start.size() == 0) chk("unexpected_wr_start", wr_start, 0);
        else begin
          e = q_start.pop_front();
          chk("wr_start_cycle", cyc, e.stamp);
          chk("wr_row", wr_row, e.a);
          chk("wr_col", wr_col, e.b);
        end
      end
      if (wr_en) begin
        n_wr++; sum_data += wr_data; last_data = wr_data; last_idx = wr_idx;
        if (q_wr.size() == 0) chk("unexpected_wr_en", wr_en, 0);
        else begin
          e = q_wr.pop_front();
          chk("wr_en_cycle", cyc, e.stamp);
          chk("wr_idx", wr_idx, e.a);
          chk("wr_data", wr_data, e.b);
        end
      end
      if (wr_done) begin
        n_done++;
        if (q_done.size() == 0) chk("unexpected_wr_done", wr_done, 0);
        else begin
          e = q_done.pop_front();
          chk("wr_done_cycle", cyc, e.stamp);
        end
      end
      if (wr_done || done) chk("done_with_wr_done", done, wr_done);
      if (q_start.size() != 0 && q_start[0].stamp < cyc) begin
        chk("missed_wr_start", cyc, q_start[0].stamp);
        void'(q_start.pop_front());
      end
      if (q_wr.size() != 0 && q_wr[0].stamp < cyc) begin
        chk("missed_wr_en", cyc, q_wr[0].stamp);
        void'(q_wr.pop_front());
      end
      if (q_done.size() != 0 && q_done[0].stamp < cyc) begin
        chk("missed_wr_done", cyc, q_done[0].stamp);
        void'(q_done.pop_front());
      end
      chk("busy", busy, (cyc >= busy_stamp) ? busy_new : busy_prev);
      chk("err", err, (cyc >= err_stamp) ? err_new : err_prev);
      chk("err_code", err_code, (cyc >= err_stamp) ? code_new : code_prev);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    model_byte(b, cyc + 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk);
    start_req = 1'b1;
    model_arm(cyc + 1);
    @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic arm_with_byte(input logic [7:0] b);
    @(negedge clk);
    start_req = 1'b1;
    rx_valid = 1'b1;
    rx_data = b;
    model_arm(cyc + 1);
    @(negedge clk);
    start_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic chk_pending(input string name);
    chk(name, q_start.size() + q_wr.size() + q_done.size(), 0);
  endtask

  function automatic logic [31:0] all_outputs();
    return {5'd0, busy, wr_start, wr_en, wr_done, done, err, err_code,
            wr_row, wr_col, wr_idx, wr_data};
  endfunction

  initial begin
    model_reset();
    clear_obs();
    wait_cycles(3);
    chk("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // nominal 2x3
    clear_obs();
    arm();
    send_str("2 3\n1 2 3\n4 5 6\n");
    wait_cycles(4);
    chk("nom_starts", n_start, 1);
    chk("nom_row", last_row, 2);
    chk("nom_col", last_col, 3);
    chk("nom_writes", n_wr, 6);
    chk("nom_sum", sum_data, 21);
    chk("nom_last_idx", last_idx, 5);
    chk("nom_done", n_done, 1);
    chk("nom_err", err, 0);
    chk("nom_busy", busy, 0);
    chk_pending("nom_pending");

    // bad dimension, error one cycle after the space following '6'
    clear_obs();
    arm();
    send_byte("6");
    send_byte(" ");
    @(negedge clk);
    rx_valid = 1'b0;
    chk("dim_err_t1", err, 1);
    chk("dim_code_t1", err_code, 2);
    chk("dim_busy_drain", busy, 1);
    send_str("2\n9 9\n");
    wait_cycles(4);
    chk("dim_starts", n_start, 0);
    chk("dim_busy", busy, 0);
    chk("dim_code", err_code, 2);
    chk_pending("dim_pending");

    // element overflow, then the largest legal element
    clear_obs();
    arm();
    send_str("1 1\n256 ");
    wait_cycles(2);
    chk("ovf_code", err_code, 3);
    chk("ovf_writes", n_wr, 0);
    chk("ovf_busy_drain", busy, 1);
    send_str("\n");
    wait_cycles(2);
    chk("ovf_busy", busy, 0);
    clear_obs();
    arm();
    chk("rearm_err_clear", err, 0);
    send_str("1 1\n255 ");
    wait_cycles(4);
    chk("max_data", last_data, 255);
    chk("max_done", n_done, 1);
    chk_pending("ovf_pending");

    // whitespace runs and CR
    clear_obs();
    arm();
    send_str("  1   1\r\n7\r\n");
    wait_cycles(4);
    chk("ws_writes", n_wr, 1);
    chk("ws_idx", last_idx, 0);
    chk("ws_data", last_data, 7);
    chk("ws_done", n_done, 1);

    // illegal character
    clear_obs();
    arm();
    send_str("1 1\nx\n");
    wait_cycles(3);
    chk("char_code", err_code, 1);
    chk("char_busy", busy, 0);
    chk("char_writes", n_wr, 0);
    chk_pending("char_pending");

    // reset after the third element of a 2x2
    clear_obs();
    arm();
    send_str("2 2\n1 2 3 ");
    wait_cycles(2);
    chk("rst_pre_writes", n_wr, 3);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("rst_no_done", n_done, 0);
    clear_obs();
    arm();
    send_str("1 2 3 4\n");
    wait_cycles(4);
    chk("rearm_row", last_row, 1);
    chk("rearm_col", last_col, 2);
    chk("rearm_writes", n_wr, 2);
    chk("rearm_last", last_data, 4);
    chk("rearm_sum", sum_data, 7);
    chk("rearm_done", n_done, 1);

    // start_req mid-parse ignored, bytes in idle ignored
    clear_obs();
    arm();
    send_str("1 ");
    arm();
    send_str("1\n4\n");
    wait_cycles(4);
    chk("busyprot_writes", n_wr, 1);
    chk("busyprot_data", last_data, 4);
    chk("busyprot_done", n_done, 1);
    send_str("3 3\n1\n");
    wait_cycles(4);
    chk("idle_starts", n_start, 1);
    chk("idle_busy", busy, 0);

    // arm and byte in the same idle cycle: byte dropped
    clear_obs();
    arm_with_byte("1");
    send_str(" 1 1\n9\n");
    wait_cycles(4);
    chk("armbyte_data", last_data, 9);
    chk("armbyte_done", n_done, 1);
    chk_pending("final_pending");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
